// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared constants and state type for the shift-add multiplier
package seq_mult_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mult_state_t;

endpackage

// File: rtl/seq_mult_ctrl.sv
// rtl/seq_mult_ctrl.sv - FSM and iteration counter sequencing load, shift and finish
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic rst_b,
  input  logic start,
  output logic load,
  output logic shift,
  output logic finish,
  output logic rdy,
  output logic done
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  mult_state_t   state;
  logic [CW-1:0] cnt;

  assign load   = (state == IDLE) && start;
  assign shift  = (state == RUN);
  assign finish = (state == FINISH);

  // rdy is registered alongside state so it mirrors state == IDLE without a decode path
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      cnt   <= '0;
      rdy   <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            cnt   <= CW'(DATA_WIDTH);
            rdy   <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FINISH;
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b1;
          rdy   <= 1'b1;
        end
        default: begin
          state <= IDLE;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_mult_sa.sv
// rtl/seq_mult_sa.sv - sequential shift-add multiplier, signed or unsigned per operation
module seq_mult_sa
  import seq_mult_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    start,
  input  logic                    signed_mode,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   B,
  output logic                    rdy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] P
);

  localparam int W = DATA_WIDTH;

  logic           load;
  logic           shift;
  logic           finish;
  logic [W-1:0]   ma;
  logic [W:0]     acc;
  logic [W-1:0]   mq;
  logic           sgn;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     sum;
  logic [2*W-1:0] mag;
  logic [2*W-1:0] p_next;

  seq_mult_ctrl #(.DATA_WIDTH(W)) u_ctrl (
    .clk    (clk),
    .rst_b  (rst_b),
    .start  (start),
    .load   (load),
    .shift  (shift),
    .finish (finish),
    .rdy    (rdy),
    .done   (done)
  );

  // Magnitudes are taken as unsigned W-bit values so -2^(W-1) maps to 2^(W-1) exactly
  assign a_mag  = (signed_mode && A[W-1]) ? (~A + 1'b1) : A;
  assign b_mag  = (signed_mode && B[W-1]) ? (~B + 1'b1) : B;
  assign sum    = acc + (mq[0] ? {1'b0, ma} : '0);
  assign mag    = {acc[W-1:0], mq};
  assign p_next = sgn ? (~mag + 1'b1) : mag;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ma  <= '0;
      acc <= '0;
      mq  <= '0;
      sgn <= 1'b0;
      P   <= '0;
    end else begin
      if (load) begin
        ma  <= a_mag;
        mq  <= b_mag;
        acc <= '0;
        sgn <= signed_mode & (A[W-1] ^ B[W-1]);
      end else if (shift) begin
        {acc, mq} <= {sum, mq} >> 1;
      end
      if (finish) P <= p_next;
    end
  end

endmodule
